// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with HI/LO pair, optional write->read bypass and a
// hardware clear sweep so the storage array itself carries no reset.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   output logic                     busy,
   input  logic [NRD*ADDR_W-1:0]    raddr,
   output logic [NRD*DATA_W-1:0]    rdata,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     hiwe,
   input  logic                     lowe,
   input  logic [DATA_W-1:0]        hi_i,
   input  logic [DATA_W-1:0]        lo_i,
   input  logic                     hir,
   input  logic                     lor,
   output logic [DATA_W-1:0]        hilodata
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic              run;
   logic              gpr_acc;
   logic              hi_acc;
   logic              lo_acc;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] rd_addr;

   // A clear request outranks every write issued in the same cycle.
   always_comb begin
      run     = (state_q == ST_RUN);
      gpr_acc = run && !clr_req && we && (waddr != '0);
      hi_acc  = run && !clr_req && hiwe;
      lo_acc  = run && !clr_req && lowe;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mem_we   = 1'b0;
      mem_addr = waddr;
      mem_din  = wdata;
      if (!run) begin
         mem_we   = 1'b1;
         mem_addr = cnt_q;
         mem_din  = '0;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
         end else begin
            cnt_d = cnt_q + CNT_FIRST;
         end
      end else if (clr_req) begin
         state_d = ST_INIT;
         cnt_d   = CNT_FIRST;
         hi_d    = '0;
         lo_d    = '0;
      end else begin
         mem_we = gpr_acc;
         if (hi_acc) begin
            hi_d = hi_i;
         end
         if (lo_acc) begin
            lo_d = lo_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= CNT_FIRST;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Entry 0 is never written; reads of address 0 are forced to zero instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_din;
      end
   end

   always_comb begin
      rdata   = '0;
      rd_addr = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_addr = raddr[k*ADDR_W +: ADDR_W];
         if (run && (rd_addr != '0)) begin
            if ((BYPASS != 0) && gpr_acc && (waddr == rd_addr)) begin
               rdata[k*DATA_W +: DATA_W] = wdata;
            end else begin
               rdata[k*DATA_W +: DATA_W] = mem_q[rd_addr];
            end
         end
      end
   end

   always_comb begin
      hilodata = '0;
      if (run) begin
         if (hir) begin
            hilodata = ((BYPASS != 0) && hi_acc) ? hi_i : hi_q;
         end else if (lor) begin
            hilodata = ((BYPASS != 0) && lo_acc) ? lo_i : lo_q;
         end
      end
   end

   assign busy = !run;

endmodule
